// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way grant arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE  = 2'b00;
    localparam arb_state_t GRANT = 2'b01;
    localparam arb_state_t GAP   = 2'b10;

    localparam logic [N_REQ-1:0] OH_0 = 4'b0001;
    localparam logic [N_REQ-1:0] OH_1 = 4'b0010;
    localparam logic [N_REQ-1:0] OH_2 = 4'b0100;
    localparam logic [N_REQ-1:0] OH_3 = 4'b1000;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] r;
        r = '0;
        case (oh)
            OH_0:    r = 2'd0;
            OH_1:    r = 2'd1;
            OH_2:    r = 2'd2;
            OH_3:    r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set req bit scanning upward from ptr+1 (ARB_FIXED_PRIO_EN: from bit 0).
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] pos;
    logic             found;

`ifdef ARB_FIXED_PRIO_EN
    // Pretending the last winner was 3 makes the scan begin at requester 0.
    assign start = IDX_W'(N_REQ - 1);
`else
    assign start = ptr;
`endif

    always_comb begin
        onehot = '0;
        found  = 1'b0;
        pos    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = start + IDX_W'(k);
            if (!found && req[pos]) begin
                onehot[pos] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign idx = onehot_to_idx(onehot);
    assign any = found;

endmodule

// File: rtl/arb_rr4_ctrl.sv
// Round-robin owner arbiter for a shared resource; fixed priority when ARB_FIXED_PRIO_EN is defined.
// Latency: grant registered 1 cycle after req sampled in IDLE; one GAP cycle after every release.
// Backpressure: owner holds until done, req drop, or MAX_HOLD cycles; other requests wait for IDLE.
module arb_rr4_ctrl
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_v,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_v_q, gnt_v_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             rel_normal;
    logic             rel_force;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // done wins over expiry in the same cycle, so a coincident finish is never flagged.
    assign rel_normal = (state_q == GRANT) && (done || !req[gnt_idx_q]);
    assign rel_force  = (state_q == GRANT) && !rel_normal && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_v_d   = gnt_v_q;
        timeout_d = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (pick_any) begin
                    gnt_d     = pick_oh;
                    gnt_idx_d = pick_idx;
                    gnt_v_d   = 1'b1;
                    ptr_d     = pick_idx;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (rel_normal || rel_force) begin
                    gnt_d     = '0;
                    gnt_idx_d = '0;
                    gnt_v_d   = 1'b0;
                    cnt_d     = '0;
                    timeout_d = rel_force;
                    busy_d    = 1'b1;
                    state_d   = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                gnt_d     = '0;
                gnt_idx_d = '0;
                gnt_v_d   = 1'b0;
                cnt_d     = '0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= IDX_W'(N_REQ - 1);
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_v_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_v_q   <= gnt_v_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_v   = gnt_v_q;
    assign timeout = timeout_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_arb_rr4_ctrl.sv
// Scoreboard bench for arb_rr4_ctrl: directed scenarios followed by random transactions.
module tb_arb_rr4_ctrl;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_v;
    logic       timeout;
    logic       busy;

    arb_rr4_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_v   (gnt_v),
        .timeout (timeout),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         start;
        logic [3:0] oh;
        logic [1:0] idx;
        int         len;
        bit         to;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   stray  = 0;
    int   ptr_m  = 3;

    task automatic check(input string nm, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Winner by the arbitration rule: scan (last+1), (last+2), ... mod 4.
    function automatic int model_pick(input logic [3:0] r);
        int base;
`ifdef ARB_FIXED_PRIO_EN
        base = 3;
`else
        base = ptr_m;
`endif
        for (int k = 1; k <= 4; k++)
            if (r[(base + k) % 4]) return (base + k) % 4;
        return -1;
    endfunction

    // Called during an IDLE cycle; returns during the next IDLE cycle.
    // mode 0: done at hold cycle k, 1: owner drops req at k, 2: never released, 3: reset at k.
    task automatic do_txn(input logic [3:0] r, input int mode, input int k);
        int         w;
        int         rel;
        bit         to;
        logic [3:0] oh;
        exp_t       e;
        if (r == 4'b0) begin
            req = 4'b0;
            repeat (k + 1) @(negedge clk);
            return;
        end
        w  = model_pick(r);
        oh = 4'(1 << w);
        ptr_m = w;
        if ((mode == 0 || mode == 1) && k <= MAX_HOLD - 1) begin
            rel = k;
            to  = 1'b0;
        end else begin
            rel = MAX_HOLD - 1;
            to  = 1'b1;
        end
        e.start = cyc + 1;
        e.oh    = oh;
        e.idx   = 2'(w);
        e.len   = rel + 1;
        e.to    = to;
        exp_q.push_back(e);
        req = r;
        @(negedge clk);
        if (mode == 3) begin
            repeat (k) begin
                req = (4'($urandom) & ~oh) | oh;
                @(negedge clk);
            end
            #2 rst_n = 1'b0;
            #1;
            check("rst_gnt", int'(gnt), 0);
            check("rst_gnt_v", int'(gnt_v), 0);
            check("rst_busy", int'(busy), 0);
            @(negedge clk);
            rst_n = 1'b1;
            req   = 4'b0;
            done  = 1'b0;
            ptr_m = 3;
            return;
        end
        for (int j = 1; j <= rel; j++) begin
            req = (4'($urandom) & ~oh) | oh;
            @(negedge clk);
        end
        if (!to && mode == 0) done = 1'b1;
        if (!to && mode == 1) req = 4'($urandom) & ~oh;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per grant and tracks its length and release.
    initial begin : monitor
        bit   prev_v   = 1'b0;
        bit   active   = 1'b0;
        bit   stable   = 1'b1;
        bit   chk_idle = 1'b0;
        bit   is_fall;
        int   hold     = 0;
        exp_t cur;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                prev_v   = 1'b0;
                active   = 1'b0;
                chk_idle = 1'b0;
                continue;
            end
            is_fall = 1'b0;
            if (chk_idle) begin
                check("idle_busy", int'(busy), 0);
                check("idle_idx", int'(gnt_idx), 0);
                chk_idle = 1'b0;
            end
            if (gnt_v && !prev_v) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_grant: got gnt=%b expected none (cycle %0d)", gnt, cyc);
                    active = 1'b0;
                end else begin
                    cur    = exp_q.pop_front();
                    active = 1'b1;
                    stable = 1'b1;
                    hold   = 1;
                    check("grant_cycle", cyc, cur.start);
                    check("gnt", int'(gnt), int'(cur.oh));
                    check("gnt_idx", int'(gnt_idx), int'(cur.idx));
                    check("busy_grant", int'(busy), 1);
                end
            end else if (gnt_v && prev_v) begin
                hold++;
                if (gnt != cur.oh || gnt_idx != cur.idx) stable = 1'b0;
            end else if (!gnt_v && prev_v && active) begin
                is_fall = 1'b1;
                check("hold_len", hold, cur.len);
                check("timeout", int'(timeout), int'(cur.to));
                check("hold_stable", int'(stable), 1);
                check("gap_busy", int'(busy), 1);
                check("gap_gnt", int'(gnt), 0);
                active   = 1'b0;
                chk_idle = 1'b1;
            end
            if (timeout && !is_fall) stray++;
            prev_v = gnt_v;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion expected finish by cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin : stimulus
        rst_n = 1'b0;
        req   = 4'b0;
        done  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_gnt", int'(gnt), 0);
        check("reset_idx", int'(gnt_idx), 0);
        check("reset_gnt_v", int'(gnt_v), 0);
        check("reset_timeout", int'(timeout), 0);
        check("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        repeat (4) do_txn(4'b0101, 0, 2);
        repeat (5) do_txn(4'b1111, 0, 1);
        repeat (2) do_txn(4'b0010, 2, 0);
        do_txn(4'b0010, 0, MAX_HOLD - 1);
        do_txn(4'b1000, 3, 3);
        do_txn(4'b1001, 0, 1);
        repeat (3) do_txn(4'b1001, 1, 0);
        do_txn(4'b0000, 0, 3);

        for (int t = 0; t < 150; t++) begin
            int m;
            m = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
            if (m == 3) do_txn(4'($urandom_range(1, 15)), 3, $urandom_range(0, 5));
            else        do_txn(4'($urandom_range(0, 15)), m, $urandom_range(0, MAX_HOLD + 3));
        end

        req = 4'b0;
        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("stray_timeout", stray, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
